// File: rtl/lfsr_burst_arbiter_if.sv
// Request/grant bus between the two random-number consumers and the shared
// LFSR burst arbiter.
interface lfsr_burst_arbiter_if #(
    parameter int LEN_W = 4
);
    logic             req0;
    logic             req1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             rnd_valid;
    logic [3:0]       rnd_data;
    logic             busy;
    logic             done;

    // The consumers drive requests and lengths and watch the burst outputs.
    modport master (
        output req0, req1, len0, len1,
        input  gnt, rnd_valid, rnd_data, busy, done
    );

    modport slave (
        input  req0, req1, len0, len1,
        output gnt, rnd_valid, rnd_data, busy, done
    );
endinterface

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that lends one 4-bit LFSR to two requesters, one burst
// of N generator steps at a time, with a one-cycle done pulse per burst.
module lfsr_burst_arbiter #(
    parameter logic [3:0] SEED  = 4'b1000,
    parameter int         LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 aset,
    lfsr_burst_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       lfsr_q, lfsr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             favour1_q, favour1_d;

    logic             pick1;
    logic [LEN_W-1:0] grant_len;

    // Requester 1 wins when it is the only one asking, or both ask and it is
    // the round-robin favourite.
    assign pick1     = bus.req1 & (~bus.req0 | favour1_q);
    assign grant_len = pick1 ? bus.len1 : bus.len0;

    always_ff @(posedge clk or posedge aset) begin
        if (aset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            favour1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            favour1_q <= favour1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        favour1_d = favour1_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (bus.req0 || bus.req1) begin
                    gnt_d     = pick1 ? 2'b10 : 2'b01;
                    cnt_d     = grant_len;
                    favour1_d = ~pick1;
                    // A zero-length burst skips straight to the done pulse.
                    state_d   = (grant_len == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                lfsr_d = {lfsr_q[3] ^ lfsr_q[2], lfsr_q[3:1]};
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_data  = lfsr_q;
    assign bus.rnd_valid = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/lfsr_burst_arbiter.md
Name: lfsr_burst_arbiter

Overview:
- Shares one 4-bit pseudo-random generator between two requesters.
- Generator recurrence: next = {q[3]^q[2], q[3:1]}.
- Each requester asks for a burst of N values. The block grants requesters round-robin, steps the generator once per burst beat and signals burst completion.
- Sits between the random-source register and its consumers, and replaces ad-hoc ena gating at each consumer.

Parameters:
- SEED, 4'b1000: generator value loaded on aset. Must be non-zero; 4'b0000 is an illegal value (lock-up state).
- LEN_W, 4: width of the burst-length inputs.

Ports:
- clk  in  1  rising-edge clock
- aset  in  1  asynchronous, active-high reset
- req0  in  1  burst request, requester 0
- req1  in  1  burst request, requester 1
- len0  in  LEN_W  burst length for requester 0; sampled at grant
- len1  in  LEN_W  burst length for requester 1; sampled at grant
- gnt  out  2  one-hot grant: bit0 = requester 0, bit1 = requester 1
- rnd_valid  out  1  rnd_data carries a beat of the current burst
- rnd_data  out  4  current generator value
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset (aset=1, asynchronous):
  - state=IDLE, lfsr=SEED, cnt=0.
  - gnt=2'b00, rnd_valid=0, done=0, busy=0.
  - Round-robin pointer favours requester 0.
  - aset mid-burst aborts immediately; no done pulse is produced.
- All outputs decode registered state only (no combinational path from req/len):
  - rnd_data = lfsr at all times.
  - rnd_valid = (state==RUN).
  - done = (state==DONE).
  - busy = (state!=IDLE).
- States: IDLE, RUN, DONE.
- IDLE:
  - No request: stay in IDLE, gnt=00.
  - Exactly one request: grant it.
  - Both requesting: grant the pointer's favourite.
  - On grant at the edge: gnt set one-hot, cnt loaded with that requester's len, pointer set to favour the other requester.
  - If the loaded len=0: next state DONE (zero-beat burst, done still pulses, generator not stepped).
  - Otherwise: next state RUN.
- RUN:
  - Each edge: lfsr <= {lfsr[3]^lfsr[2], lfsr[3:1]}, cnt <= cnt-1.
  - When cnt==1 at the edge: next state DONE.
  - Burst of length L gives exactly L consecutive rnd_valid cycles. The first beat presents the generator value held at grant time.
- DONE:
  - Lasts one cycle: done=1, gnt held, lfsr frozen.
  - Next state IDLE, gnt cleared.
  - Minimum gap between bursts is therefore one IDLE cycle; a pending request is granted on the edge leaving IDLE.
- Request handling:
  - req and len changes while busy are ignored; a granted burst always runs to completion.
  - Requester holds req until done; it may keep req high to ask again.
  - A req still high in IDLE after done is treated as a new request.
- Generator:
  - Never reseeded except by aset; state persists across bursts and across requesters.
  - Stepped only in RUN.
- Widths:
  - cnt is LEN_W bits; maximum burst is 2^LEN_W-1 beats.
  - Decrement never wraps, because RUN exits at cnt==1.

Test Plan:
1. aset pulse, then release -> gnt=00, rnd_valid=0, busy=0, rnd_data=4'b1000; generator does not step with no requests.
2. req0=1, len0=3 -> gnt=01. rnd_valid high 3 cycles with rnd_data 1000, 1100, 0110. Then done for 1 cycle, then gnt=00.
3. Following scenario 2, req1=1, len1=2 -> gnt=10, rnd_data 1011, 1101, done pulse. Generator state carries over from the previous burst, and the next value is 0110.
4. req0 and req1 both high continuously, len0=len1=1 -> grants alternate 01, 10, 01, 10 starting with 01. Each burst is 1 valid cycle, 1 done cycle, 1 IDLE cycle.
5. req0=1, len0=0 -> gnt=01, done pulse with no rnd_valid, rnd_data unchanged.
6. aset asserted during the 2nd beat of a len=4 burst -> outputs clear immediately, rnd_data=1000, no done pulse. After release, IDLE grants a pending request normally.
